// File: rtl/sop_accumulator_pkg.sv
// Shared types and sizing helpers for the sum-of-products accumulator.
// Imported by the accumulator top and its adder.
package sop_accumulator_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int IN_W_DEF  = 9;
  localparam int N_DEF     = 4;
  localparam int ACC_W_DEF = IN_W_DEF + clog2(N_DEF);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/sop_accumulator_acc_adder.sv
// Ripple-carry adder for the frame accumulator, plus its full-adder cell.
// Carry-in is fixed at zero; the carry-out is exposed but not needed.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module acc_adder
  import sop_accumulator_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  assign c[0] = 1'b0;
  assign co   = c[W];

  for (genvar i = 0; i < W; i++) begin : g_bit
    fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

endmodule

// File: rtl/sop_accumulator.sv
// Accumulates N sum-of-products samples into one frame total and
// returns it over a valid/ready handshake.
module sop_accumulator
  import sop_accumulator_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int N     = N_DEF,
  parameter int ACC_W = IN_W + clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy
);

  localparam int CW = clog2(N);

  state_e           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             unused_co;

  assign in_ready = (state == ACCUM) && !clear;
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CW'(N - 1));
  assign busy     = (state == HOLD) || (cnt != '0);

  acc_adder #(
    .W (ACC_W)
  ) u_add (
    .a  (acc),
    .b  ({{(ACC_W-IN_W){1'b0}}, in_data}),
    .s  (sum),
    .co (unused_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      state     <= ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (accept && last) begin
            out_data  <= sum;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            state     <= HOLD;
          end else if (accept) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sop_accumulator.sv
// Directed and randomized checks of sop_accumulator against a
// queue-based frame model.
module tb_sop_accumulator;

  localparam int IN_W  = 9;
  localparam int N     = 4;
  localparam int ACC_W = 11;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             busy;

  int errors = 0;
  int checks = 0;

  int m_q[$];
  bit m_hold;
  int m_od;

  sop_accumulator #(
    .IN_W  (IN_W),
    .N     (N),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_hold = 1'b0;
    m_od   = 0;
  endtask

  // One clock cycle: drive, check in_ready, update model, check outputs.
  task automatic tick(input logic iv, input int d, input logic ordy,
                      input logic clr);
    in_valid  = iv;
    in_data   = IN_W'(d);
    out_ready = ordy;
    clear     = clr;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_hold && !clr));
    if (clr) begin
      m_q.delete();
      m_hold = 1'b0;
    end else if (m_hold) begin
      if (ordy) m_hold = 1'b0;
    end else if (iv) begin
      m_q.push_back(d);
      if (m_q.size() == N) begin
        m_od   = m_q.sum();
        m_hold = 1'b1;
        m_q.delete();
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_hold));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("busy", 32'(busy), 32'(m_hold || m_q.size() != 0));
  endtask

  initial begin
    int acc_n;
    int guard;
    int bubbles;
    int d4[4];

    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame 5,330,250,50 then three stalled cycles before the handshake.
    d4 = '{5, 330, 250, 50};
    foreach (d4[i]) tick(1'b1, d4[i], 1'b0, 1'b0);
    chk("frame1_total", 32'(out_data), 635);
    for (int i = 0; i < 3; i++) tick(1'b1, int'($urandom_range(0, 511)), 1'b0, 1'b0);
    chk("frame1_stall", 32'(out_data), 635);
    tick(1'b1, 17, 1'b1, 1'b0);
    chk("frame1_taken", 32'(out_valid), 0);

    // Four samples of 511 with random in_valid gaps.
    acc_n = 0;
    guard = 0;
    while (acc_n < N && guard < 100) begin
      if ($urandom_range(0, 1) == 1) begin
        tick(1'b1, 511, 1'b0, 1'b0);
        acc_n++;
      end else begin
        tick(1'b0, int'($urandom_range(0, 511)), 1'b0, 1'b0);
      end
      guard++;
    end
    chk("max_guard", 32'(acc_n), N);
    chk("max_total", 32'(out_data), 2044);
    tick(1'b0, 0, 1'b1, 1'b0);

    // Clear drops the partial frame and the sample presented with it.
    tick(1'b1, 100, 1'b1, 1'b0);
    tick(1'b1, 200, 1'b1, 1'b0);
    tick(1'b1, 7, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) tick(1'b1, i, 1'b1, 1'b0);
    chk("clear_total", 32'(out_data), 10);
    tick(1'b0, 0, 1'b1, 1'b0);

    // Clear in HOLD discards the pending total even with out_ready.
    for (int i = 0; i < 4; i++) tick(1'b1, 30, 1'b0, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b1);
    chk("clear_hold", 32'(out_valid), 0);

    // Asynchronous reset after three accepted samples.
    for (int i = 0; i < 3; i++) tick(1'b1, 9, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    model_reset();
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_busy", 32'(busy), 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) tick(1'b1, 9, 1'b0, 1'b0);
    chk("arst_total", 32'(out_data), 36);
    tick(1'b0, 0, 1'b1, 1'b0);

    // Back-to-back frames, out_ready held: one bubble per frame.
    bubbles = 0;
    for (int i = 0; i < 2 * (N + 1); i++) begin
      if (in_valid && !in_ready) bubbles++;
      tick(1'b1, int'($urandom_range(0, 511)), 1'b1, 1'b0);
    end
    if (in_valid && !in_ready) bubbles++;
    chk("b2b_bubbles", 32'(bubbles), 2);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      tick(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 511)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
